// File: rtl/mem_router_pkg.sv
// Shared router configuration: region table, timeout default and FSM state type.
// Imported by the address decoder, the bus interface and the mem_router top.
package configure;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] top;
    } region_t;

    localparam int region_count = 6;

    // Half-open [base, top) windows; lower index wins on overlap.
    localparam region_t region_map [region_count] = '{
        '{32'h0000_0000, 32'h0000_0080},   // rom
        '{32'h0100_0000, 32'h0100_0004},   // print
        '{32'h0200_0000, 32'h0200_C000},   // clint
        '{32'h1000_0000, 32'h1010_0000},   // tim0
        '{32'h2000_0000, 32'h2010_0000},   // tim1
        '{32'h8000_0000, 32'h9000_0000}    // ram
    };

    localparam int router_timeout_cycles = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ERROR = 2'd2
    } router_state_t;

endpackage

// File: rtl/mem_router_if.sv
// Core-side and target-side bus of mem_router. The master modport is the
// core/targets view; the slave modport is the router's own view.
interface mem_router_if
    import configure::*;
#(
    parameter int slave_count = region_count
);
    logic                         m_valid;
    logic                         m_instr;
    logic [31:0]                  m_addr;
    logic [31:0]                  m_wdata;
    logic [3:0]                   m_wstrb;
    logic [31:0]                  m_rdata;
    logic                         m_ready;
    logic                         m_error;

    logic [slave_count-1:0]       s_valid;
    logic                         s_instr;
    logic [31:0]                  s_addr;
    logic [31:0]                  s_wdata;
    logic [3:0]                   s_wstrb;
    logic [slave_count-1:0][31:0] s_rdata;
    logic [slave_count-1:0]       s_ready;

    modport master (
        output m_valid, m_instr, m_addr, m_wdata, m_wstrb,
        input  m_rdata, m_ready, m_error,
        input  s_valid, s_instr, s_addr, s_wdata, s_wstrb,
        output s_rdata, s_ready
    );

    modport slave (
        input  m_valid, m_instr, m_addr, m_wdata, m_wstrb,
        output m_rdata, m_ready, m_error,
        output s_valid, s_instr, s_addr, s_wdata, s_wstrb,
        input  s_rdata, s_ready
    );

endinterface

// File: rtl/mem_router_decode.sv
// router_decode: combinational address-to-target priority decoder over the
// first slave_count entries of region_map.
module router_decode
    import configure::*;
#(
    parameter int slave_count = region_count,
    parameter int idx_w       = (slave_count > 1) ? $clog2(slave_count) : 1
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [idx_w-1:0] index
);

    // Scanning from the highest index down lets the lowest matching index win.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = slave_count - 1; i >= 0; i--) begin
            if (addr >= region_map[i].base && addr < region_map[i].top) begin
                hit   = 1'b1;
                index = idx_w'(i);
            end
        end
    end

endmodule

// File: rtl/mem_router.sv
// mem_router: routes one outstanding core request to the target whose region
// matches. Optional busy-timeout error response under `ROUTER_TIMEOUT_EN.
module mem_router
    import configure::*;
#(
    parameter int slave_count    = region_count,
    parameter int timeout_cycles = router_timeout_cycles
) (
    input  logic         clock,
    input  logic         reset,
    mem_router_if.slave  bus
);

    localparam int idx_w = (slave_count > 1) ? $clog2(slave_count) : 1;

    router_state_t    state;
    logic [idx_w-1:0] sel;
    logic             issue;
    logic             hit;
    logic [idx_w-1:0] hit_idx;
    logic             busy;
    logic             rdy_sel;
    logic             tmo;

    router_decode #(
        .slave_count (slave_count),
        .idx_w       (idx_w)
    ) u_decode (
        .addr  (bus.m_addr),
        .hit   (hit),
        .index (hit_idx)
    );

    assign busy    = (state == BUSY);
    assign rdy_sel = bus.s_ready[sel];

`ifdef ROUTER_TIMEOUT_EN
    localparam int cnt_w = $clog2(timeout_cycles + 1);

    logic [cnt_w-1:0] cnt;
    logic [cnt_w-1:0] cnt_inc;

    // Fires on the BUSY cycle whose increment would reach timeout_cycles.
    assign cnt_inc = cnt + 1'b1;
    assign tmo     = busy && (cnt_inc == cnt_w'(timeout_cycles));

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == IDLE && bus.m_valid && hit) begin
            cnt <= '0;
        end else if (busy && !rdy_sel) begin
            cnt <= cnt_inc;
        end
    end
`else
    // Without the timeout feature this is constant-false for any legal timeout_cycles.
    assign tmo = busy && (timeout_cycles < 1);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= '0;
            issue       <= 1'b0;
            bus.s_instr <= 1'b0;
            bus.s_addr  <= '0;
            bus.s_wdata <= '0;
            bus.s_wstrb <= '0;
        end else begin
            issue <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.m_valid) begin
                        bus.s_instr <= bus.m_instr;
                        bus.s_addr  <= bus.m_addr;
                        bus.s_wdata <= bus.m_wdata;
                        bus.s_wstrb <= bus.m_wstrb;
                        if (hit) begin
                            sel   <= hit_idx;
                            issue <= 1'b1;
                            state <= BUSY;
                        end else begin
                            state <= ERROR;
                        end
                    end
                end
                BUSY: begin
                    if (rdy_sel || tmo) begin
                        state <= IDLE;
                    end
                end
                ERROR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_valid = issue ? (slave_count'(1) << sel) : '0;

    // A same-cycle ready beats the timeout; a timed-out response carries no data.
    always_comb begin
        bus.m_ready = 1'b0;
        bus.m_error = 1'b0;
        bus.m_rdata = '0;
        if (busy) begin
            bus.m_ready = rdy_sel || tmo;
            bus.m_error = tmo && !rdy_sel;
            bus.m_rdata = (tmo && !rdy_sel) ? 32'h0 : bus.s_rdata[sel];
        end else if (state == ERROR) begin
            bus.m_ready = 1'b1;
            bus.m_error = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_router.sv
// Scoreboard bench for mem_router: stimulus queues expected target requests and
// core responses; a negedge monitor pops and compares whenever the DUT presents one.
module tb_mem_router;

    localparam int N = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_router_if #(.slave_count(N)) bus ();

    mem_router #(
        .slave_count    (N),
        .timeout_cycles (16)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [N-1:0] sel;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [3:0]   wstrb;
        logic         instr;
        int           cyc;
    } req_t;

    rsp_t rsp_q[$];
    req_t req_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitor: compare every target request and core response against the queues.
    always @(negedge clk) begin
        rsp_t e;
        req_t r;
        if (bus.m_ready === 1'b1) begin
            if (rsp_q.size() == 0) begin
                chk("spurious m_ready", 32'(bus.m_ready), 32'd0);
            end else begin
                e = rsp_q.pop_front();
                chk("m_rdata", bus.m_rdata, e.rdata);
                chk("m_error", 32'(bus.m_error), 32'(e.err));
                chk("m_ready cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (bus.m_error !== 1'b0) begin
            chk("m_error without m_ready", 32'(bus.m_error), 32'd0);
        end
        if (bus.s_valid !== '0) begin
            if (req_q.size() == 0) begin
                chk("spurious s_valid", 32'(bus.s_valid), 32'd0);
            end else begin
                r = req_q.pop_front();
                chk("s_valid", 32'(bus.s_valid), 32'(r.sel));
                chk("s_addr", bus.s_addr, r.addr);
                chk("s_wdata", bus.s_wdata, r.wdata);
                chk("s_wstrb", 32'(bus.s_wstrb), 32'(r.wstrb));
                chk("s_instr", 32'(bus.s_instr), 32'(r.instr));
                chk("s_valid cycle", 32'(cyc), 32'(r.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input int idx, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic instr, input int c);
        req_t r;
        r.sel   = N'(1) << idx;
        r.addr  = addr;
        r.wdata = wdata;
        r.wstrb = wstrb;
        r.instr = instr;
        r.cyc   = c;
        req_q.push_back(r);
    endtask

    task automatic push_rsp(input logic [31:0] rdata, input logic err, input int c);
        rsp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.cyc   = c;
        rsp_q.push_back(e);
    endtask

    // Presents a one-cycle request in the current cycle; returns one cycle later.
    task automatic send(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic instr);
        bus.m_valid = 1'b1;
        bus.m_addr  = addr;
        bus.m_wdata = wdata;
        bus.m_wstrb = wstrb;
        bus.m_instr = instr;
        tick();
        bus.m_valid = 1'b0;
    endtask

    task automatic respond(input int idx, input logic [31:0] data);
        bus.s_ready[idx] = 1'b1;
        bus.s_rdata[idx] = data;
        tick();
        bus.s_ready = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " m_ready"}, 32'(bus.m_ready), 32'd0);
        chk({tag, " m_error"}, 32'(bus.m_error), 32'd0);
        chk({tag, " m_rdata"}, bus.m_rdata, 32'd0);
        chk({tag, " s_valid"}, 32'(bus.s_valid), 32'd0);
        chk({tag, " s_addr"}, bus.s_addr, 32'd0);
        chk({tag, " s_wdata"}, bus.s_wdata, 32'd0);
        chk({tag, " s_wstrb"}, 32'(bus.s_wstrb), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        bus.m_valid = 1'b0;
        bus.m_instr = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_wstrb = '0;
        bus.s_rdata = '0;
        bus.s_ready = '0;

        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // RAM read, target ready three cycles after s_valid.
        t = cyc;
        push_req(5, 32'h8000_0010, 32'h0, 4'h0, 1'b0, t + 1);
        push_rsp(32'hDEAD_BEEF, 1'b0, t + 4);
        send(32'h8000_0010, 32'h0, 4'h0, 1'b0);
        repeat (3) tick();
        respond(5, 32'hDEAD_BEEF);

        // Print write answered in the s_valid cycle, then a back-to-back rom fetch.
        t = cyc;
        push_req(1, 32'h0100_0000, 32'h41, 4'h1, 1'b0, t + 1);
        push_rsp(32'h0000_0007, 1'b0, t + 1);
        send(32'h0100_0000, 32'h41, 4'h1, 1'b0);
        respond(1, 32'h0000_0007);
        t = cyc;
        push_req(0, 32'h0000_007C, 32'h0, 4'h0, 1'b1, t + 1);
        push_rsp(32'h0000_0013, 1'b0, t + 2);
        send(32'h0000_007C, 32'h0, 4'h0, 1'b1);
        tick();
        respond(0, 32'h0000_0013);

        // Unmapped address; a request during the error cycle is dropped.
        t = cyc;
        push_rsp(32'h0, 1'b1, t + 1);
        send(32'h4000_0000, 32'h0, 4'h0, 1'b0);
        send(32'h8000_0000, 32'h0, 4'h0, 1'b0);
        t = cyc;
        push_rsp(32'h0, 1'b1, t + 1);
        send(32'h0000_0080, 32'h0, 4'h0, 1'b0);
        tick();
        t = cyc;
        push_rsp(32'h0, 1'b1, t + 1);
        send(32'h0100_0004, 32'h0, 4'h0, 1'b0);
        tick();

        // Spurious ready from target 3 and a request while BUSY on target 5.
        t = cyc;
        push_req(5, 32'h8000_0020, 32'hAA, 4'hF, 1'b0, t + 1);
        push_rsp(32'h1234_5678, 1'b0, t + 3);
        send(32'h8000_0020, 32'hAA, 4'hF, 1'b0);
        tick();
        bus.s_ready[3] = 1'b1;
        bus.s_rdata[3] = 32'h0000_0BAD;
        send(32'h0000_0000, 32'h0, 4'h0, 1'b0);
        bus.s_ready = '0;
        chk("s_addr held in BUSY", bus.s_addr, 32'h8000_0020);
        respond(5, 32'h1234_5678);

        // Reset in the middle of a RAM access; the later ready must be ignored.
        t = cyc;
        push_req(5, 32'h8000_0040, 32'h0, 4'h0, 1'b0, t + 1);
        send(32'h8000_0040, 32'h0, 4'h0, 1'b0);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check_idle_outputs("after reset");
        tick();
        bus.s_ready[5] = 1'b1;
        bus.s_rdata[5] = 32'h0000_CAFE;
        #1;
        chk("late s_ready ignored", 32'(bus.m_ready), 32'd0);
        tick();
        bus.s_ready = '0;

`ifdef ROUTER_TIMEOUT_EN
        // Clint never answers: error on the 16th BUSY cycle, data forced to zero.
        bus.s_rdata[2] = 32'h0000_0077;
        t = cyc;
        push_req(2, 32'h0200_0004, 32'h0, 4'h0, 1'b0, t + 1);
        push_rsp(32'h0, 1'b1, t + 16);
        send(32'h0200_0004, 32'h0, 4'h0, 1'b0);
        repeat (16) tick();
        respond(2, 32'h0000_0099);
        // Ready on the 16th BUSY cycle beats the timeout.
        t = cyc;
        push_req(2, 32'h0200_0008, 32'h0, 4'h0, 1'b0, t + 1);
        push_rsp(32'h0000_0055, 1'b0, t + 16);
        send(32'h0200_0008, 32'h0, 4'h0, 1'b0);
        repeat (15) tick();
        respond(2, 32'h0000_0055);
`else
        // Without the timeout, a slow clint is simply waited for.
        t = cyc;
        push_req(2, 32'h0200_0004, 32'h0, 4'h0, 1'b0, t + 1);
        push_rsp(32'h0000_0055, 1'b0, t + 21);
        send(32'h0200_0004, 32'h0, 4'h0, 1'b0);
        repeat (20) tick();
        respond(2, 32'h0000_0055);
`endif

        repeat (5) tick();
        chk("response queue drained", 32'(rsp_q.size()), 32'd0);
        chk("request queue drained", 32'(req_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
